// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a small MIPS subset (R-type ALU, ori, lui, lw, sw, beq, j, nop).
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (halt on unrecognised instructions instead of treating them as nop).
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] instr,
    input  logic        eq,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_b_sel,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic        reg_dst,
    output logic        wd_sel,
    output logic        done,
    output logic        illegal,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       nop_q;
    logic [2:0] next_state;

    logic dec_r, dec_ori, dec_lui, dec_lw, dec_sw, dec_beq, dec_j, dec_known;

    // nop is a full-word match, so a latched flag is kept alongside opcode/funct.
    assign dec_r     = (opcode == 6'b000000) && !nop_q &&
                       ((funct == 6'b100001) || (funct == 6'b100011) ||
                        (funct == 6'b100100) || (funct == 6'b100101));
    assign dec_ori   = (opcode == 6'b001101);
    assign dec_lui   = (opcode == 6'b001111);
    assign dec_lw    = (opcode == 6'b100011);
    assign dec_sw    = (opcode == 6'b101011);
    assign dec_beq   = (opcode == 6'b000100);
    assign dec_j     = (opcode == 6'b000010);
    assign dec_known = dec_r | dec_ori | dec_lui | dec_lw | dec_sw | dec_beq | dec_j | nop_q;

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (dec_j || nop_q)
                    next_state = S_FETCH;
                else if (dec_known)
                    next_state = S_EXEC;
                else
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    next_state = S_HALT;
`else
                    next_state = S_FETCH;
`endif
            end
            S_EXEC:   next_state = dec_beq ? S_FETCH : ((dec_lw || dec_sw) ? S_MEM : S_WB);
            S_MEM:    next_state = dec_lw ? S_WB : S_FETCH;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            opcode <= 6'd0;
            funct  <= 6'd0;
            nop_q  <= 1'b0;
        end else if (en) begin
            state <= next_state;
            if (state == S_FETCH) begin
                opcode <= instr[31:26];
                funct  <= instr[5:0];
                nop_q  <= (instr == 32'd0);
            end
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal <= 1'b0;
        else if (en && (state == S_DECODE) && (next_state == S_HALT))
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    // Outputs are Moore functions of state and the latched instruction; beq's pc_wr follows eq only in EXEC.
    always_comb begin
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        pc_src    = 2'b00;
        alu_op    = 3'b000;
        alu_b_sel = 2'b00;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        reg_dst   = 1'b0;
        wd_sel    = 1'b0;
        done      = 1'b0;
        case (state)
            S_FETCH: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
            end
            S_DECODE: begin
                if (dec_j) begin
                    pc_wr  = 1'b1;
                    pc_src = 2'b10;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                done = dec_j | nop_q;
`else
                done = dec_j | nop_q | ~dec_known;
`endif
            end
            S_EXEC: begin
                if (dec_r) begin
                    case (funct)
                        6'b100011: alu_op = 3'b001;
                        6'b100100: alu_op = 3'b010;
                        6'b100101: alu_op = 3'b011;
                        default:   alu_op = 3'b000;
                    endcase
                end else if (dec_ori) begin
                    alu_op    = 3'b011;
                    alu_b_sel = 2'b01;
                end else if (dec_lui) begin
                    alu_op    = 3'b100;
                    alu_b_sel = 2'b01;
                end else if (dec_lw || dec_sw) begin
                    alu_b_sel = 2'b10;
                end else if (dec_beq) begin
                    alu_op = 3'b001;
                    pc_src = 2'b01;
                    pc_wr  = eq;
                    done   = 1'b1;
                end
            end
            S_MEM: begin
                mem_wr = dec_sw;
                done   = dec_sw;
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = dec_r;
                wd_sel  = dec_lw;
                done    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized checks of mc_ctrl against an instruction-level trace model.
// Follows MC_CTRL_ILLEGAL_TRAP_EN when it is defined for the build.
module tb_mc_ctrl;

    localparam int C_R = 0, C_ORI = 1, C_LUI = 2, C_LW = 3, C_SW = 4,
                   C_BEQ = 5, C_J = 6, C_NOP = 7, C_BAD = 8;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] instr;
    logic        eq;
    logic        ir_wr, pc_wr, mem_wr, reg_wr, reg_dst, wd_sel, done, illegal;
    logic [1:0]  pc_src, alu_b_sel;
    logic [2:0]  alu_op, state;

    int checks = 0;
    int errors = 0;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .instr     (instr),
        .eq        (eq),
        .ir_wr     (ir_wr),
        .pc_wr     (pc_wr),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .alu_b_sel (alu_b_sel),
        .mem_wr    (mem_wr),
        .reg_wr    (reg_wr),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .done      (done),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction class straight from the recognised-instruction list.
    function automatic int classify(input logic [31:0] i);
        if (i == 32'd0) return C_NOP;
        case (i[31:26])
            6'b000000: return (i[5:0] == 6'h21 || i[5:0] == 6'h23 ||
                               i[5:0] == 6'h24 || i[5:0] == 6'h25) ? C_R : C_BAD;
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            default:   return C_BAD;
        endcase
    endfunction

    // Expected per-cycle outputs for an instruction in a given state.
    function automatic logic [17:0] expect_out(input logic [31:0] i, input logic [2:0] s,
                                               input logic e, input logic ill);
        int c;
        logic irw, pcw, memw, regw, dst, wd, dn;
        logic [1:0] src, bsel;
        logic [2:0] op;
        c = classify(i);
        {irw, pcw, memw, regw, dst, wd, dn} = 7'd0;
        src = 2'd0; bsel = 2'd0; op = 3'd0;
        case (s)
            3'd0: begin irw = 1'b1; pcw = 1'b1; end
            3'd1: begin
                if (c == C_J) begin pcw = 1'b1; src = 2'b10; dn = 1'b1; end
                if (c == C_NOP) dn = 1'b1;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                if (c == C_BAD) dn = 1'b1;
`endif
            end
            3'd2: begin
                case (c)
                    C_R: op = (i[5:0] == 6'h21) ? 3'd0 : (i[5:0] == 6'h23) ? 3'd1 :
                              (i[5:0] == 6'h24) ? 3'd2 : 3'd3;
                    C_ORI: begin op = 3'd3; bsel = 2'b01; end
                    C_LUI: begin op = 3'd4; bsel = 2'b01; end
                    C_LW, C_SW: bsel = 2'b10;
                    C_BEQ: begin op = 3'd1; src = 2'b01; pcw = e; dn = 1'b1; end
                    default: ;
                endcase
            end
            3'd3: begin memw = (c == C_SW); dn = (c == C_SW); end
            3'd4: begin regw = 1'b1; dst = (c == C_R); wd = (c == C_LW); dn = 1'b1; end
            default: ;
        endcase
        return {s, irw, pcw, src, op, bsel, memw, regw, dst, wd, dn, ill};
    endfunction

    task automatic get_path(input int c, output int n, output logic [2:0] p [5]);
        p = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd4};
        case (c)
            C_R, C_ORI, C_LUI: n = 4;
            C_LW:  begin n = 5; p[3] = 3'd3; end
            C_SW:  begin n = 4; p[3] = 3'd3; end
            C_BEQ: n = 3;
            default: n = 2;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = {state, ir_wr, pc_wr, pc_src, alu_op, alu_b_sel, mem_wr, reg_wr, reg_dst, wd_sel, done, illegal};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s state=%0d observed=%05h expected=%05h", tag, state, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] i, input logic en_v,
                                 input logic eq_v, input logic [17:0] exp);
        @(negedge clk);
        instr = i;
        en    = en_v;
        eq    = eq_v;
        #1;
        checkOutput(tag, exp);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput(tag, expect_out(32'd0, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b0;
    endtask

    // Runs one instruction along its path; stalls either random or forced in one state.
    task automatic run_instr(input string tag, input logic [31:0] ins, input bit rnd,
                             input logic eq_exec, input logic [2:0] stall_st, input int stall_n);
        int n, stalls;
        logic [2:0] p [5];
        logic [2:0] s;
        logic [31:0] drv;
        logic eqv;
        get_path(classify(ins), n, p);
        for (int k = 0; k < n; k++) begin
            s = p[k];
            if (rnd) stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            else     stalls = (s == stall_st) ? stall_n : 0;
            for (int j = 0; j < stalls; j++) begin
                drv = rnd ? $urandom : 32'hFFFF_FFFF;
                eqv = rnd ? 1'($urandom_range(0, 1)) : ((s == 3'd2) ? eq_exec : ~eq_exec);
                applyStimulus({tag, "_stall"}, drv, 1'b0, eqv, expect_out(ins, s, eqv, 1'b0));
            end
            drv = (s == 3'd0) ? ins : (rnd ? $urandom : 32'hFFFF_FFFF);
            eqv = rnd ? 1'($urandom_range(0, 1)) : ((s == 3'd2) ? eq_exec : ~eq_exec);
            applyStimulus(tag, drv, 1'b1, eqv, expect_out(ins, s, eqv, 1'b0));
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (classify(ins) == C_BAD) begin
            for (int j = 0; j < 3; j++) begin
                eqv = 1'($urandom_range(0, 1));
                applyStimulus({tag, "_halt"}, $urandom, 1'($urandom_range(0, 1)), eqv,
                              expect_out(ins, 3'd7, eqv, 1'b1));
            end
            pulse_reset({tag, "_halt_reset"});
        end
`endif
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0] fn [4];
        fn = '{6'h21, 6'h23, 6'h24, 6'h25};
        r = $urandom;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        case ($urandom_range(0, 7))
`else
        case ($urandom_range(0, 9))
`endif
            0: return {6'b000000, r[25:6], fn[$urandom_range(0, 3)]};
            1: return {6'b001101, r[25:0]};
            2: return {6'b001111, r[25:0]};
            3: return {6'b100011, r[25:0]};
            4: return {6'b101011, r[25:0]};
            5: return {6'b000100, r[25:0]};
            6: return {6'b000010, r[25:0]};
            7: return 32'd0;
            8: return {6'b111111, r[25:0]};
            default: return {6'b000000, 5'd1, r[20:6], 6'b000000};
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        instr = 32'd0;
        eq    = 1'b0;

        applyStimulus("reset_en0", 32'h0022_1821, 1'b0, 1'b0, expect_out(32'd0, 3'd0, 1'b0, 1'b0));
        applyStimulus("reset_en1", 32'hFFFF_FFFF, 1'b1, 1'b1, expect_out(32'd0, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b0;

        run_instr("addu", 32'h0022_1821, 1'b0, 1'b0, 3'd5, 0);
        run_instr("lw",   32'h8C22_0004, 1'b0, 1'b0, 3'd5, 0);
        run_instr("sw",   32'hAC22_0004, 1'b0, 1'b0, 3'd5, 0);
        run_instr("beq1", 32'h1022_0003, 1'b0, 1'b1, 3'd5, 0);
        run_instr("beq0", 32'h1022_0003, 1'b0, 1'b0, 3'd5, 0);
        run_instr("lui_stall", 32'h3C01_ABCD, 1'b0, 1'b0, 3'd2, 3);
        run_instr("j",    32'h0800_0010, 1'b0, 1'b0, 3'd5, 0);
        run_instr("nop",  32'h0000_0000, 1'b0, 1'b0, 3'd5, 0);

        // ori abandoned by a reset raised mid-cycle in EXEC
        applyStimulus("ori_fetch",  32'h3421_00FF, 1'b1, 1'b0, expect_out(32'h3421_00FF, 3'd0, 1'b0, 1'b0));
        applyStimulus("ori_decode", 32'hFFFF_FFFF, 1'b1, 1'b0, expect_out(32'h3421_00FF, 3'd1, 1'b0, 1'b0));
        applyStimulus("ori_exec",   32'hFFFF_FFFF, 1'b1, 1'b0, expect_out(32'h3421_00FF, 3'd2, 1'b0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ori_async_reset", expect_out(32'd0, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        checkOutput("ori_reset_held", expect_out(32'd0, 3'd0, 1'b0, 1'b0));
        en    = 1'b0;
        reset = 1'b0;
        run_instr("after_reset_nop", 32'h0000_0000, 1'b0, 1'b0, 3'd5, 0);

        run_instr("illegal", 32'hFC00_0000, 1'b0, 1'b0, 3'd5, 0);
        run_instr("post_illegal_addu", 32'h0022_1821, 1'b0, 1'b0, 3'd5, 0);

        for (int t = 0; t < 200; t++)
            run_instr("rand", rand_instr(), 1'b1, 1'b0, 3'd5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 The ports SHALL be:
- clk  in  1  system clock, rising edge.
- reset  in  1  async active-high reset.
- en  in  1  advance enable; 0 freezes the FSM and internal state.
- instr  in  32  instruction-memory output; sampled only in FETCH.
- eq  in  1  ALU operand-equality flag, consumed in EXEC.
- ir_wr  out  1  IR load strobe.
- pc_wr  out  1  PC load strobe.
- pc_src  out  2  next PC: 00 = PC+4, 01 = branch target, 10 = jump target.
- alu_op  out  3  operation: 000 ADDU, 001 SUBU, 010 AND, 011 OR, 100 LUI.
- alu_b_sel  out  2  ALU B operand: 00 = rt, 01 = zero-ext imm16, 10 = sign-ext imm16.
- mem_wr  out  1  data-memory write strobe.
- reg_wr  out  1  register-file write strobe.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- wd_sel  out  1  write data: 0 = ALU result, 1 = memory data.
- done  out  1  one-cycle pulse in the last state of each instruction.
- illegal  out  1  sticky unrecognised-instruction flag.
- state  out  3  current state, for debug.
- No parameters.

Function
REQ-003 State encoding SHALL be: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 7.
REQ-004 The FSM SHALL advance only on a rising clk edge with en = 1; when en = 0 all state, including the latched opcode/funct, SHALL hold and outputs SHALL stay stable.
REQ-005 In FETCH with en = 1: ir_wr = 1, pc_wr = 1, pc_src = 00, and opcode/funct are latched from instr[31:26] and instr[5:0].
REQ-006 Decoding SHALL use only the latched copy, never live instr, in every state after FETCH.
REQ-007 Recognised instructions:
- opcode 000000 with funct 100001 addu, 100011 subu, 100100 and, 100101 or.
- instr == 0 is nop.
- 001101 ori, 001111 lui, 100011 lw, 101011 sw, 000100 beq, 000010 j.
REQ-008 State paths, with outputs that are Moore functions of state plus latched opcode/funct:
- R-type / ori / lui: FETCH -> DECODE -> EXEC -> WB.
- lw: FETCH -> DECODE -> EXEC -> MEM -> WB.
- sw: FETCH -> DECODE -> EXEC -> MEM.
- beq: FETCH -> DECODE -> EXEC.
- j, nop: FETCH -> DECODE.
REQ-009 EXEC output settings:
- addu/subu/and/or: alu_op per REQ-002 encoding, alu_b_sel = 00.
- ori: OR, alu_b_sel = 01.
- lui: LUI, alu_b_sel = 01.
- lw/sw: ADDU, alu_b_sel = 10.
- beq: SUBU, alu_b_sel = 00, pc_src = 01, pc_wr = eq.
REQ-010 DECODE for j SHALL assert pc_wr = 1 with pc_src = 10.
REQ-011 MEM SHALL assert mem_wr = 1 for sw only.
REQ-012 WB output settings:
- All WB instructions: reg_wr = 1.
- R-type: reg_dst = 1, wd_sel = 0.
- ori/lui: reg_dst = 0, wd_sel = 0.
- lw: reg_dst = 0, wd_sel = 1.
REQ-013 done SHALL be 1 in the final state of each path and 0 elsewhere.
REQ-014 All strobes not explicitly asserted SHALL be 0, and all select outputs SHALL be 0 when not specified.
REQ-015 CPI SHALL be exactly 4/5/4/3/2/2 for R-type-ALU-imm / lw / sw / beq / j / nop, counted in enabled cycles.
REQ-016 beq SHALL sample eq only in EXEC; eq changes in other states SHALL have no effect.

Reset
REQ-017 Asserting reset SHALL immediately force state = FETCH, the latched opcode/funct = 0, and illegal = 0, independent of clk and en.
REQ-018 Reset asserted mid-instruction SHALL abandon that instruction with no further strobes; the first cycle after release SHALL be FETCH.
REQ-019 During reset the outputs SHALL equal the FETCH decode: ir_wr = 1, pc_wr = 1, and all other outputs 0.

Configuration
REQ-020 The macro MC_CTRL_ILLEGAL_TRAP_EN SHALL select how an unrecognised instruction in DECODE is handled.
- Defined: go to HALT, set illegal = 1, and stay in HALT with all strobes 0 until reset.
- Undefined: treat the instruction as nop (DECODE -> FETCH, done = 1), and illegal SHALL be constant 0.

Verification
REQ-021 Reset, then addu (0x00221821) with en = 1 -> states 0,1,2,4; EXEC alu_op = 000; WB reg_wr = 1, reg_dst = 1; done in cycle 4.
REQ-022 lw (0x8C220004) then sw (0xAC220004) -> lw takes 5 cycles with wd_sel = 1 in WB; sw takes 4 cycles with mem_wr = 1 only in MEM; reg_wr is never 1 for sw.
REQ-023 beq (0x10220003) with eq = 1, then again with eq = 0 -> pc_wr = 1, pc_src = 01 in EXEC for the first; pc_wr = 0 in EXEC for the second; eq toggled in DECODE is ignored.
REQ-024 lui (0x3C01ABCD) with en pulsed low for 3 cycles during EXEC, and instr changed to 0xFFFFFFFF meanwhile -> the state holds, alu_op stays 100, and the WB strobes are still lui's.
REQ-025 ori in progress, reset asserted asynchronously in EXEC -> state = 0 at once, with no WB reg_wr after release.
REQ-026 instr 0xFC000000 -> with the macro defined: state = 7, illegal = 1, held until reset; without it: 2-cycle nop with illegal = 0.
